// File: rtl/hft_reg_mailbox.sv
// Register mailbox: shadow bank -> snapshot command (valid/busy handshake), results queued in a FWFT FIFO.
// Commit to o_cmd_valid is one edge; core backpressure holds ISSUE; a full FIFO with no pop drops results.
module hft_reg_mailbox #(
  parameter int REG_WIDTH      = 32,
  parameter int NUM_IN_REGS    = 8,
  parameter int NUM_OUT_REGS   = 7,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                               i_clk,
  input  logic                                               i_reset,
  input  logic                                               i_wr_en,
  input  logic [((NUM_IN_REGS > 1) ? $clog2(NUM_IN_REGS) : 1)-1:0] i_wr_addr,
  input  logic [REG_WIDTH-1:0]                               i_wr_data,
  input  logic                                               i_commit,
  input  logic                                               i_book_is_busy,
  output logic                                               o_cmd_valid,
  output logic [NUM_IN_REGS*REG_WIDTH-1:0]                   o_cmd_regs,
  input  logic                                               i_res_valid,
  input  logic [NUM_OUT_REGS*REG_WIDTH-1:0]                  i_res_regs,
  output logic                                               o_res_valid,
  output logic [NUM_OUT_REGS*REG_WIDTH-1:0]                  o_res_regs,
  input  logic                                               i_res_pop,
  output logic [$clog2(FIFO_DEPTH):0]                        o_fifo_count,
  output logic                                               o_busy,
  output logic                                               o_commit_drop,
  output logic                                               o_overflow,
  output logic                                               o_timeout,
  input  logic                                               i_clear_flags
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int OW = NUM_OUT_REGS * REG_WIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES} state_e;

  state_e                                       state_q, state_d;
  logic [NUM_IN_REGS-1:0][REG_WIDTH-1:0]        shadow_q, shadow_d;
  logic [NUM_IN_REGS-1:0][REG_WIDTH-1:0]        snap_q, snap_d;
  logic [TW-1:0]                                timer_q, timer_d;
  logic [FIFO_DEPTH-1:0][OW-1:0]                mem_q, mem_d;
  logic [PW-1:0]                                wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                                rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                                count_q, count_d;
  logic                                         drop_q, drop_d;
  logic                                         ovf_q, ovf_d;
  logic                                         tmo_q, tmo_d;

  logic expire, full, empty, do_push, do_pop;

  assign expire = (timer_q == TW'(TIMEOUT_CYCLES - 1));
  assign full   = (count_q == CW'(FIFO_DEPTH));
  assign empty  = (count_q == '0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (i_commit) state_d = ISSUE;
      ISSUE:    if (!i_book_is_busy) state_d = WAIT_RES;
      WAIT_RES: if (i_res_valid || expire) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    o_cmd_valid = (state_q == ISSUE);
    o_busy      = (state_q != IDLE);
  end

  always_comb begin
    shadow_d = shadow_q;
    if (i_wr_en && (32'(i_wr_addr) < NUM_IN_REGS)) shadow_d[i_wr_addr] = i_wr_data;

    // Snapshot takes the post-write shadow so a same-cycle write is included.
    snap_d = snap_q;
    if (state_q == IDLE && i_commit) snap_d = shadow_d;

    timer_d = (state_q == WAIT_RES) ? timer_q + 1'b1 : '0;

    // At full, a pop frees the slot the push writes into on the same edge.
    do_pop   = i_res_pop && !empty;
    do_push  = i_res_valid && (!full || do_pop);
    mem_d    = mem_q;
    if (do_push) mem_d[wr_ptr_q] = i_res_regs;
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);

    drop_d = (i_commit && state_q != IDLE) || (drop_q && !i_clear_flags);
    ovf_d  = (i_res_valid && full && !i_res_pop) || (ovf_q && !i_clear_flags);
    tmo_d  = (state_q == WAIT_RES && expire && !i_res_valid) || (tmo_q && !i_clear_flags);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      shadow_q <= '0;
      snap_q   <= '0;
      timer_q  <= '0;
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= 1'b0;
      ovf_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      snap_q   <= snap_d;
      timer_q  <= timer_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
      tmo_q    <= tmo_d;
    end
  end

  assign o_cmd_regs    = snap_q;
  assign o_res_valid   = !empty;
  assign o_res_regs    = mem_q[rd_ptr_q];
  assign o_fifo_count  = count_q;
  assign o_commit_drop = drop_q;
  assign o_overflow    = ovf_q;
  assign o_timeout     = tmo_q;

endmodule
